// File: rtl/mem_arb_defs.sv
// Shared definitions for the memory arbiter: FSM state encoding and default
// geometry/latency parameters.
package mem_arb_defs;

  localparam int DEF_AW      = 16;
  localparam int DEF_DW      = 16;
  localparam int DEF_LAT     = 4;
  localparam int DEF_MAXSKIP = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_DM_BUSY = 2'd2,
    ST_ERR     = 2'd3
  } arb_state_t;

endpackage

// File: rtl/lat_counter.sv
// Down-counter that times one fixed-latency memory access: load LAT, count
// down to zero, report zero.
module lat_counter #(
  parameter int LAT = 4,
  parameter int CW  = $clog2(LAT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(LAT);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between instruction fetch
// and data access: data first, with a skip counter that guarantees fetch progress.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int LAT     = DEF_LAT,
  parameter int MAXSKIP = DEF_MAXSKIP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  input  logic          halt,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          idle,
  output logic          err
);

  // Handshake: a requester raises req and holds it (with stable address/data)
  // until its done pulses for exactly one cycle; requests are sampled only in
  // IDLE, so a request seen during BUSY simply waits for the next IDLE cycle.

  localparam int SW = $clog2(MAXSKIP + 2);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] skip_q, skip_d;
  logic          err_q, err_d;
  logic          if_err_done_q, if_err_done_d;
  logic          dm_err_done_q, dm_err_done_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_zero;
  logic          busy;
  logic          dm_wins;
  logic          if_wins;
  logic [SW-1:0] skip_on_dm;
  logic          if_finish;
  logic          dm_finish;

  lat_counter #(.LAT(LAT)) u_lat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  // Data wins unless fetch has already been passed over MAXSKIP times in a row.
  assign dm_wins = dm_req && (!if_req || halt || (skip_q < SW'(MAXSKIP)));
  assign if_wins = !dm_wins && if_req && !halt;

  // A data grant only counts as a skip when fetch was actually eligible.
  assign skip_on_dm = (if_req && !halt && (skip_q != SW'(MAXSKIP)))
                      ? skip_q + SW'(1) : skip_q;

  assign busy    = (state_q == ST_IF_BUSY) || (state_q == ST_DM_BUSY);
  assign cnt_dec = busy && !cnt_zero;

  always_comb begin
    state_d       = state_q;
    skip_d        = skip_q;
    err_d         = err_q;
    if_err_done_d = 1'b0;
    dm_err_done_d = 1'b0;
    mem_en_d      = 1'b0;
    mem_wr_d      = 1'b0;
    mem_addr_d    = '0;
    mem_wdata_d   = '0;
    cnt_load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dm_wins) begin
          skip_d = skip_on_dm;
          if (dm_addr[0]) begin
            state_d       = ST_ERR;
            err_d         = 1'b1;
            dm_err_done_d = 1'b1;
          end else begin
            state_d     = ST_DM_BUSY;
            mem_en_d    = 1'b1;
            mem_wr_d    = dm_wr;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wr ? dm_wdata : '0;
            cnt_load    = 1'b1;
          end
        end else if (if_wins) begin
          skip_d = '0;
          if (if_addr[0]) begin
            state_d       = ST_ERR;
            err_d         = 1'b1;
            if_err_done_d = 1'b1;
          end else begin
            state_d    = ST_IF_BUSY;
            mem_en_d   = 1'b1;
            mem_addr_d = if_addr;
            cnt_load   = 1'b1;
          end
        end
      end
      ST_IF_BUSY, ST_DM_BUSY: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      skip_q        <= '0;
      err_q         <= 1'b0;
      if_err_done_q <= 1'b0;
      dm_err_done_q <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      skip_q        <= skip_d;
      err_q         <= err_d;
      if_err_done_q <= if_err_done_d;
      dm_err_done_q <= dm_err_done_d;
      mem_en_q      <= mem_en_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  // The counter reaches zero in the same cycle the memory presents read data.
  assign if_finish = (state_q == ST_IF_BUSY) && cnt_zero;
  assign dm_finish = (state_q == ST_DM_BUSY) && cnt_zero;

  assign if_done   = if_finish || if_err_done_q;
  assign dm_done   = dm_finish || dm_err_done_q;
  assign if_rdata  = if_finish ? mem_rdata : '0;
  assign dm_rdata  = dm_finish ? mem_rdata : '0;

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign err  = err_q;
  assign idle = (state_q == ST_IDLE) && !err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/data timing, arbitration order, halt,
// misaligned error and asynchronous reset during an access.
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          halt;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          idle;
  logic          err;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] exp_q[$];

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .MAXSKIP(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .halt      (halt),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .idle      (idle),
    .err       (err)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Memory model: read data appears exactly LAT cycles after a read strobe.
  logic [LAT-1:0] rd_pipe = '0;
  logic [AW-1:0]  rd_addr = '0;
  always @(posedge clk) begin
    rd_pipe <= {rd_pipe[LAT-2:0], mem_en && !mem_wr};
    if (mem_en) rd_addr <= mem_addr;
  end
  assign mem_rdata = rd_pipe[LAT-1] ? (16'hC000 ^ rd_addr) : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_en(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!mem_en && n < 20);
    if (!mem_en) n = -1;
  endtask

  task automatic wait_done(input bit is_dm, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!(is_dm ? dm_done : if_done) && n < 20);
    if (!(is_dm ? dm_done : if_done)) n = -1;
  endtask

  task automatic clear_inputs;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_wr    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    halt     = 1'b0;
  endtask

  initial begin
    int  n;
    int  cnt;
    bit  is_dm;
    logic [AW-1:0] exp;

    clear_inputs();
    rst_n = 1'b0;
    step(2);
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_dones", {if_done, dm_done}, 0);
    rst_n = 1'b1;
    step(1);

    // Fetch only
    if_addr = 16'h0010;
    if_req  = 1'b1;
    wait_en(n);
    chk("if_en_lat", n, 1);
    chk("if_mem_addr", mem_addr, 16'h0010);
    chk("if_mem_wr", mem_wr, 0);
    chk("if_busy_idle", idle, 0);
    wait_done(1'b0, n);
    chk("if_done_lat", n, 4);
    chk("if_rdata", if_rdata, 16'hC010);
    chk("if_no_dm_done", dm_done, 0);
    if_req = 1'b0;
    step(1);
    chk("if_back_idle", idle, 1);
    chk("if_done_pulse", if_done, 0);

    // Data write
    dm_addr  = 16'h0020;
    dm_wdata = 16'hBEEF;
    dm_wr    = 1'b1;
    dm_req   = 1'b1;
    wait_en(n);
    chk("wr_en_lat", n, 1);
    chk("wr_mem_wr", mem_wr, 1);
    chk("wr_mem_addr", mem_addr, 16'h0020);
    chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
    step(1);
    chk("wr_en_pulse", mem_en, 0);
    chk("wr_wdata_zero", mem_wdata, 0);
    wait_done(1'b1, n);
    chk("wr_done_lat", n, 3);
    dm_req = 1'b0;
    dm_wr  = 1'b0;
    dm_wdata = '0;
    step(1);
    chk("wr_back_idle", idle, 1);

    // Data read
    dm_addr = 16'h0042;
    dm_req  = 1'b1;
    wait_en(n);
    chk("rd_en_lat", n, 1);
    chk("rd_mem_wr", mem_wr, 0);
    wait_done(1'b1, n);
    chk("rd_done_lat", n, 4);
    chk("rd_rdata", dm_rdata, 16'hC042);
    chk("rd_no_if_done", if_done, 0);
    dm_req = 1'b0;
    step(1);

    // Both held: DM, DM, IF, DM, DM, IF
    exp_q = '{16'h0200, 16'h0200, 16'h0100, 16'h0200, 16'h0200, 16'h0100};
    if_addr = 16'h0100;
    dm_addr = 16'h0200;
    if_req  = 1'b1;
    dm_req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_en(n);
      chk("arb_gap", n, (i == 0) ? 1 : 2);
      exp = exp_q.pop_front();
      chk("arb_addr", mem_addr, exp);
      is_dm = (exp == 16'h0200);
      wait_done(is_dm, n);
      chk("arb_done_lat", n, 4);
      chk("arb_rdata", is_dm ? dm_rdata : if_rdata, 16'hC000 ^ exp);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    step(1);
    chk("arb_back_idle", idle, 1);

    // Halt: in-flight fetch completes, then only data is served
    if_addr = 16'h0300;
    if_req  = 1'b1;
    wait_en(n);
    chk("halt_if_en", mem_addr, 16'h0300);
    halt    = 1'b1;
    dm_addr = 16'h0400;
    dm_req  = 1'b1;
    wait_done(1'b0, n);
    chk("halt_if_done_lat", n, 4);
    chk("halt_if_rdata", if_rdata, 16'hC300);
    for (int i = 0; i < 3; i++) begin
      wait_en(n);
      chk("halt_dm_gap", n, 2);
      chk("halt_dm_addr", mem_addr, 16'h0400);
      wait_done(1'b1, n);
      chk("halt_dm_done_lat", n, 4);
      chk("halt_dm_rdata", dm_rdata, 16'hC400);
    end
    dm_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (mem_en) cnt++;
    end
    chk("halt_no_fetch", cnt, 0);
    chk("halt_idle", idle, 1);
    halt = 1'b0;
    wait_en(n);
    chk("unhalt_en_lat", n, 1);
    chk("unhalt_addr", mem_addr, 16'h0300);
    wait_done(1'b0, n);
    chk("unhalt_done_lat", n, 4);
    if_req = 1'b0;
    step(1);

    // Misaligned data address
    dm_addr = 16'h0031;
    dm_req  = 1'b1;
    step(1);
    chk("mis_done", dm_done, 1);
    chk("mis_err", err, 1);
    chk("mis_no_en", mem_en, 0);
    chk("mis_rdata", dm_rdata, 0);
    chk("mis_idle", idle, 0);
    dm_req = 1'b0;
    step(1);
    chk("mis_done_pulse", dm_done, 0);
    chk("mis_err_sticky", err, 1);
    if_addr = 16'h0010;
    if_req  = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (mem_en || if_done) cnt++;
    end
    chk("mis_no_grant", cnt, 0);
    chk("mis_err_held", err, 1);
    if_req = 1'b0;

    // Reset mid-access
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("rst2_err_clear", err, 0);
    chk("rst2_idle", idle, 1);
    dm_addr = 16'h0050;
    dm_req  = 1'b1;
    wait_en(n);
    chk("rst3_en_lat", n, 1);
    step(1);
    rst_n  = 1'b0;
    dm_req = 1'b0;
    #1;
    chk("rst3_idle", idle, 1);
    chk("rst3_mem_en", mem_en, 0);
    chk("rst3_mem_addr", mem_addr, 0);
    chk("rst3_dm_done", dm_done, 0);
    step(1);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (dm_done || mem_en) cnt++;
    end
    chk("rst3_no_done", cnt, 0);
    chk("rst3_final_idle", idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one fixed-latency, single-ported memory between the instruction-fetch port and the data-memory port of the processor datapath. Data accesses (driven by the decoder's memRead/memWrite) have priority; a starvation counter guarantees fetch progress. The block sequences each access with a small FSM and a latency counter, flags misaligned addresses as a sticky error, and stops fetch grants on halt.

## Interface
- AW, 16, address width
- DW, 16, data width
- LAT, 4, memory read/write latency in cycles (≥1)
- MAXSKIP, 2, consecutive fetch denials before fetch wins
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until if_done
- if_addr  in  AW  fetch address
- if_done  out  1  one-cycle fetch completion
- if_rdata  out  DW  fetch data, valid with if_done
- dm_req  in  1  data request, held until dm_done
- dm_wr  in  1  1 = write, 0 = read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_done  out  1  one-cycle data completion (read or write)
- dm_rdata  out  DW  read data, valid with dm_done
- halt  in  1  level; blocks new fetch grants
- mem_en  out  1  memory access strobe, one cycle
- mem_wr  out  1  write strobe qualifier
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory data, valid LAT cycles after mem_en
- idle  out  1  FSM in IDLE and no error
- err  out  1  sticky misaligned-access error

## Operation
- States: IDLE, IF_BUSY, DM_BUSY, ERR.
- IDLE, err=0: arbitrate on sampled requests.
  - dm_req and (not if_req, or halt, or skip<MAXSKIP) → DM_BUSY; skip increments (saturating) if if_req && !halt, else holds.
  - else if_req && !halt → IF_BUSY; skip clears.
  - Granted address with bit 0 set → ERR instead of BUSY; no mem_en.
- Entering BUSY: mem_en/mem_wr/mem_addr/mem_wdata registered, valid for the first BUSY cycle only (mem_wr=0 for fetch); counter loads LAT.
- BUSY: counter decrements each cycle; at 0, matching done pulses, rdata = mem_rdata combinationally, next state IDLE.
- ERR: err set; the granted requester's done pulses once (rdata=0); FSM stays in ERR until reset; no further grants.
- halt only gates new fetch grants; an in-flight fetch completes; data still served.
- Outputs not valid (rdata, mem_addr, mem_wdata) drive 0.

## Timing
- Reset (async): state IDLE, counter 0, skip 0, err 0, all mem_* 0, both done 0, idle 1. Reset mid-access abandons it; no done is produced.
- Request sampled high in IDLE in cycle N → mem_en in cycle N+1 → done in cycle N+1+LAT → IDLE in cycle N+2+LAT.
- Requester deasserts req in the cycle after done, or keeps it high to issue a new request; earliest next mem_en at N+3+LAT.
- Requests during BUSY are not sampled; the sibling waits.
- Misaligned: request in cycle N → ERR and done in cycle N+1; err high from N+1.
- Both requests, skip==MAXSKIP → fetch wins.

## Structure
- Shared package/header mem_arb_defs: state encodings, default AW/DW/LAT/MAXSKIP.
- Sub-module lat_counter (load, decrement, zero flag, width $clog2(LAT+1)).
- FSM, arbitration and skip counter live in mem_arbiter.

## Test plan
- Fetch only, LAT=4, if_addr=0x0010: if_req at cycle 0 → mem_en at 1 with addr 0x0010, if_done at 5 with mem_rdata, idle at 6.
- Data write dm_addr=0x0020, dm_wdata=0xBEEF → mem_en, mem_wr=1, mem_wdata=0xBEEF at cycle 1; dm_done at 5.
- Both requests held continuously → grant order DM, DM, IF, DM, DM, IF (MAXSKIP=2).
- halt=1 with if_req and dm_req → only DM granted; in-flight fetch at halt assertion still completes.
- dm_addr=0x0031 → no mem_en, dm_done next cycle, err=1 sticky; later if_req never granted until rst_n low.
- rst_n pulled low two cycles into DM_BUSY → all outputs reset immediately, no dm_done afterwards, idle=1.
